regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port ena  input  1  block enable; gates writes, clear progress and read outputs.
REQ-006 SHALL provide ports we0/we1  input  1  write enables, write ports 0 and 1.
REQ-007 SHALL provide ports waddr0/waddr1  input  ADDR_W  write addresses.
REQ-008 SHALL provide ports wdata0/wdata1  input  DATA_W  write data.
REQ-009 SHALL provide ports raddr0/raddr1  input  ADDR_W  read addresses.
REQ-010 SHALL provide ports rdata0/rdata1  output  DATA_W  read data.
REQ-011 SHALL provide port clr_req  input  1  one-cycle request to start a sequential clear.
REQ-012 SHALL provide port busy  output  1  high while a sequential clear is in progress.

Function
REQ-013 Register 0 SHALL always read zero; writes addressed to 0 SHALL be discarded.
REQ-014 A write on port k SHALL commit at the rising edge when ena=1, wek=1, waddrk!=0 and state is IDLE.
REQ-015 Both ports writing the same nonzero address in one cycle SHALL commit wdata1 (port 1 wins).
REQ-016 Reads SHALL be combinational: rdataN = stored[raddrN] when ena=1; rdataN = 0 when ena=0 (no high-impedance output).
REQ-017 State machine SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-018 IDLE -> CLEAR SHALL occur at the edge where clr_req=1 and ena=1; writes sampled in that same cycle SHALL still commit.
REQ-019 In CLEAR, an index counter starting at 1 SHALL zero register[index] and increment by 1 each edge with ena=1.
REQ-020 ena=0 in CLEAR SHALL freeze the counter and state; no register is modified.
REQ-021 CLEAR -> IDLE SHALL occur at the edge that zeroes register DEPTH-1; busy deasserts the following cycle; total busy time = DEPTH-1 enabled cycles (31 with defaults).
REQ-022 In CLEAR, all port writes SHALL be ignored and clr_req SHALL be ignored (no restart).
REQ-023 In CLEAR, reads SHALL return current stored contents (already-cleared entries read 0, others old values).
REQ-024 Counter SHALL be ADDR_W bits and SHALL not wrap past DEPTH-1 to 0.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously zero all DEPTH registers, set state IDLE, counter 1, busy 0.
REQ-026 Reset asserted mid-CLEAR SHALL abort the clear; after release the block is IDLE with all registers zero.
REQ-027 Reset SHALL take effect regardless of ena.
REQ-028 With rst_n=0 and ena=1, rdata0/rdata1 SHALL read 0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: a read whose address equals a write committing in the same cycle (per REQ-014/015, nonzero address) SHALL return that write data combinationally, port 1 priority.
REQ-030 REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value; new data visible the cycle after the write.
REQ-031 Bypass SHALL never apply in CLEAR or when ena=0.

Verification
REQ-032 Reset release, ena=1, we0=1 waddr0=3 wdata0=0xDEADBEEF -> next cycle raddr0=3 gives 0xDEADBEEF; raddr1=0 gives 0.
REQ-033 we0/we1 both to address 7, wdata0=0x11, wdata1=0x22 -> register 7 = 0x22; we0 to address 0 -> rdata reads 0.
REQ-034 Fill registers 1..31 with index value, pulse clr_req -> busy high for exactly 31 cycles; mid-clear read of reg 20 at counter 10 returns 20; after busy falls all reads 0; writes during busy discarded.
REQ-035 Clear with ena dropped for 5 cycles at counter 8 -> busy lasts 36 cycles total; reg 8 unchanged during pause.
REQ-036 rst_n pulsed low mid-clear at counter 12 -> busy 0 immediately, all registers 0, subsequent write to 5 commits normally.
REQ-037 Write 0x55 to reg 9 with raddr0=9 same cycle -> rdata0=0x55 that cycle with REGFILE_BYPASS_EN, old value without; ena=0 -> rdata0=0.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file with sequential clear
//
// Two write ports, two combinational read ports, register 0 hard-wired to zero.
// A one-cycle clr_req starts a sequential clear that zeroes registers
// 1..DEPTH-1, one per enabled clock, while busy is high.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read of an address being written in the same cycle returns
//               the write data combinationally (port 1 has priority).
//   undefined : reads always return the stored (pre-edge) contents.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset (zeroes every register)
//   ena              block enable: gates writes, clear progress and read data
//   we0/we1          write enables, ports 0 and 1
//   waddr0/waddr1    write addresses
//   wdata0/wdata1    write data
//   raddr0/raddr1    read addresses
//   rdata0/rdata1    read data (zero when ena=0 or during reset)
//   clr_req          one-cycle request to start a sequential clear
//   busy             high while the sequential clear is in progress
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   input  logic              clr_req,
   output logic              busy
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_idle;
   logic                w_wr0;
   logic                w_wr1;
   logic                w_clr_step;
   logic                w_clr_last;
   logic                w_busy;
   logic [DATA_W-1:0]   w_rdata0;
   logic [DATA_W-1:0]   w_rdata1;

   // --------------------------------------------------------------------------
   // Qualified write / clear strobes
   // --------------------------------------------------------------------------
   assign w_idle     = (r_state == S_IDLE);

   // Writes only land in IDLE; address 0 is discarded so register 0 stays zero.
   assign w_wr0      = ena && we0 && (waddr0 != '0) && w_idle;
   assign w_wr1      = ena && we1 && (waddr1 != '0) && w_idle;

   // The clear advances only on enabled cycles; ena=0 freezes it in place.
   assign w_clr_step = ena && (r_state == S_CLEAR);
   assign w_clr_last = w_clr_step && (r_idx == LAST_IDX);

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (ena && clr_req) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            // clr_req is deliberately ignored here: a clear cannot restart.
            if (w_clr_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   always_comb begin
      w_busy = 1'b0;
      if (r_state == S_CLEAR) begin
         w_busy = 1'b1;
      end
   end

   assign busy = w_busy;

   // --------------------------------------------------------------------------
   // Clear index counter
   // --------------------------------------------------------------------------
   // Starts at 1 (register 0 needs no clearing) and returns to 1 on the edge
   // that clears the last register, so it never wraps through 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= FIRST_IDX;
      end else if (w_clr_step) begin
         if (w_clr_last) begin
            r_idx <= FIRST_IDX;
         end else begin
            r_idx <= r_idx + FIRST_IDX;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Storage array
   // --------------------------------------------------------------------------
   // Write strobes are IDLE-only and the clear strobe is CLEAR-only, so the
   // clear never collides with a port write. Port 1 is written last so that
   // it wins when both ports target the same address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_clr_step) begin
            r_mem[r_idx] <= '0;
         end
         if (w_wr0) begin
            r_mem[waddr0] <= wdata0;
         end
         if (w_wr1) begin
            r_mem[waddr1] <= wdata1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Read ports
   // --------------------------------------------------------------------------
   // Gating with rst_n keeps the outputs at zero during reset even if a
   // bypass match would otherwise forward write data. The write strobes are
   // already qualified with ena and IDLE, so bypass never fires in CLEAR.
   always_comb begin
      w_rdata0 = '0;
      if (ena && rst_n && (raddr0 != '0)) begin
         w_rdata0 = r_mem[raddr0];
`ifdef REGFILE_BYPASS_EN
         if (w_wr1 && (waddr1 == raddr0)) begin
            w_rdata0 = wdata1;
         end else if (w_wr0 && (waddr0 == raddr0)) begin
            w_rdata0 = wdata0;
         end
`else
         // Stored (pre-edge) value only; new data is visible next cycle.
`endif
      end
   end

   always_comb begin
      w_rdata1 = '0;
      if (ena && rst_n && (raddr1 != '0)) begin
         w_rdata1 = r_mem[raddr1];
`ifdef REGFILE_BYPASS_EN
         if (w_wr1 && (waddr1 == raddr1)) begin
            w_rdata1 = wdata1;
         end else if (w_wr0 && (waddr0 == raddr1)) begin
            w_rdata1 = wdata0;
         end
`else
         // Stored (pre-edge) value only; new data is visible next cycle.
`endif
      end
   end

   assign rdata0 = w_rdata0;
   assign rdata1 = w_rdata1;

endmodule
